// File: rtl/mips_defs.sv
// Shared P7 pipeline definitions: word type, memory map, reset/handler PCs and
// ExcCode values used by the fetch stage and its next-PC selector.
package mips_defs;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  exc_code_t;

  localparam word_t RESET_PC  = 32'h0000_3000;
  localparam word_t EXC_ENTRY = 32'h0000_4180;
  localparam word_t IM_BASE   = 32'h0000_3000;
  localparam word_t IM_LIMIT  = 32'h0000_6ffc;
  localparam word_t PC_STEP   = 32'h0000_0004;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_INT  = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;
  localparam exc_code_t EXC_RI   = 5'd10;
  localparam exc_code_t EXC_OV   = 5'd12;

  // Source chosen for the next architectural PC, highest priority first.
  typedef enum logic [2:0] {
    NpcReq,
    NpcHold,
    NpcEret,
    NpcJump,
    NpcBranch,
    NpcSeq
  } npc_src_e;

  // A fetch is illegal when misaligned or outside the instruction memory window.
  function automatic logic fetch_addr_bad(input word_t addr, input word_t base,
                                          input word_t limit);
    logic misaligned;
    logic below;
    logic above;
    misaligned = (addr[1:0] != 2'b00);
    below      = (addr < base);
    above      = (addr > limit);
    return misaligned | below | above;
  endfunction

endpackage

// File: rtl/f_npc_sel.sv
// Combinational next-PC priority mux for the fetch stage: exception entry,
// stall, eret, jump, taken branch, then sequential fetch.
module f_npc_sel
  import mips_defs::*;
#(
  parameter word_t ExcEntry = EXC_ENTRY
) (
  input  logic  req_i,
  input  logic  wr_en_i,
  input  logic  eret_i,
  input  word_t epc_i,
  input  logic  jump_i,
  input  word_t jump_target_i,
  input  logic  br_taken_i,
  input  word_t br_target_i,
  input  word_t pc_i,
  output word_t npc_o
);

  npc_src_e src;
  word_t    pc_plus4;
  word_t    epc_plus4;

  // Both adds wrap modulo 2^32; the carry is intentionally dropped.
  assign pc_plus4  = pc_i + PC_STEP;
  assign epc_plus4 = epc_i + PC_STEP;

  always_comb begin
    src = NpcSeq;
    if (req_i) begin
      src = NpcReq;
    end else if (!wr_en_i) begin
      src = NpcHold;
    end else if (eret_i) begin
      src = NpcEret;
    end else if (jump_i) begin
      src = NpcJump;
    end else if (br_taken_i) begin
      src = NpcBranch;
    end
  end

  always_comb begin
    npc_o = pc_plus4;
    unique case (src)
      NpcReq:    npc_o = ExcEntry;
      NpcHold:   npc_o = pc_i;
      NpcEret:   npc_o = epc_plus4;
      NpcJump:   npc_o = jump_target_i;
      NpcBranch: npc_o = br_target_i;
      NpcSeq:    npc_o = pc_plus4;
      default:   npc_o = pc_plus4;
    endcase
  end

endmodule

// File: rtl/f_fetch_stage.sv
// P7 fetch stage: holds the fetch PC, drives the IM address and packages
// PC, instruction, delay-slot flag and fetch ExcCode for the F/D register.
module f_fetch_stage
  import mips_defs::*;
#(
  parameter word_t     ResetPc  = RESET_PC,
  parameter word_t     ExcEntry = EXC_ENTRY,
  parameter word_t     ImBase   = IM_BASE,
  parameter word_t     ImLimit  = IM_LIMIT,
  parameter exc_code_t ExcAdel  = EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WrEn,
  input  logic        Req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        D_br_taken,
  input  logic [31:0] D_br_target,
  input  logic        D_jump,
  input  logic [31:0] D_jump_target,
  input  logic        D_is_bj,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic        F_Delayslot,
  output logic [4:0]  F_EXCcode
);

  word_t pc_q;
  word_t pc_d;
  word_t fetch_pc;
  logic  addr_bad;

  f_npc_sel #(
    .ExcEntry(ExcEntry)
  ) u_npc_sel (
    .req_i        (Req),
    .wr_en_i      (WrEn),
    .eret_i       (D_eret),
    .epc_i        (EPC),
    .jump_i       (D_jump),
    .jump_target_i(D_jump_target),
    .br_taken_i   (D_br_taken),
    .br_target_i  (D_br_target),
    .pc_i         (pc_q),
    .npc_o        (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  // eret has no delay slot, so its target is fetched while eret is still in D.
  assign fetch_pc = D_eret ? EPC : pc_q;
  assign addr_bad = fetch_addr_bad(fetch_pc, ImBase, ImLimit);

  always_comb begin
    i_inst_addr = fetch_pc;
    F_PC        = fetch_pc;
    F_Instr     = i_inst_rdata;
    F_EXCcode   = EXC_NONE;
    if (addr_bad) begin
      F_Instr   = 32'h0;
      F_EXCcode = ExcAdel;
    end
  end

  assign F_Delayslot = D_is_bj & ~D_eret;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed scenarios plus a randomized run checked
// against a PC-level reference model with a hashed instruction memory.
module tb_f_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        WrEn;
  logic        Req;
  logic        D_eret;
  logic [31:0] EPC;
  logic        D_br_taken;
  logic [31:0] D_br_target;
  logic        D_jump;
  logic [31:0] D_jump_target;
  logic        D_is_bj;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_Delayslot;
  logic [4:0]  F_EXCcode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  f_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .WrEn         (WrEn),
    .Req          (Req),
    .D_eret       (D_eret),
    .EPC          (EPC),
    .D_br_taken   (D_br_taken),
    .D_br_target  (D_br_target),
    .D_jump       (D_jump),
    .D_jump_target(D_jump_target),
    .D_is_bj      (D_is_bj),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_PC         (F_PC),
    .F_Instr      (F_Instr),
    .F_Delayslot  (F_Delayslot),
    .F_EXCcode    (F_EXCcode)
  );

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
  endfunction

  assign i_inst_rdata = im_word(i_inst_addr);

  function automatic logic addr_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; WrEn = 1'b1; Req = 1'b0; D_eret = 1'b0; EPC = 32'h0;
    D_br_taken = 1'b0; D_br_target = 32'h0; D_jump = 1'b0; D_jump_target = 32'h0;
    D_is_bj = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests += 4;
    if (F_PC !== 32'h3000) begin
      n_fail++; $display("FAIL reset_pc got %h want %h", F_PC, 32'h3000);
    end
    if (F_EXCcode !== 5'd0) begin
      n_fail++; $display("FAIL reset_exc got %0d want 0", F_EXCcode);
    end
    if (F_Instr !== im_word(32'h3000)) begin
      n_fail++; $display("FAIL reset_instr got %h want %h", F_Instr, im_word(32'h3000));
    end
    if (F_Delayslot !== 1'b0) begin
      n_fail++; $display("FAIL reset_ds got %b want 0", F_Delayslot);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests += 2;
      if (F_PC !== 32'h3000 + 32'(4 * i)) begin
        n_fail++; $display("FAIL seq_pc%0d got %h want %h", i, F_PC, 32'h3000 + 32'(4 * i));
      end
      if (F_EXCcode !== 5'd0) begin
        n_fail++; $display("FAIL seq_exc%0d got %0d want 0", i, F_EXCcode);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    WrEn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (F_PC !== 32'h3010) begin
        n_fail++; $display("FAIL stall_hold%0d got %h want %h", i, F_PC, 32'h3010);
      end
    end
    WrEn = 1'b1;
    tick();
    n_tests++;
    if (F_PC !== 32'h3014) begin
      n_fail++; $display("FAIL stall_release got %h want %h", F_PC, 32'h3014);
    end
  endtask

  task automatic test_branch();
    D_jump = 1'b1; D_jump_target = 32'h3020;
    tick();
    idle_inputs();
    D_is_bj = 1'b1; D_br_taken = 1'b1; D_br_target = 32'h3100;
    #1;
    n_tests += 2;
    if (F_PC !== 32'h3020) begin
      n_fail++; $display("FAIL br_slot_pc got %h want %h", F_PC, 32'h3020);
    end
    if (F_Delayslot !== 1'b1) begin
      n_fail++; $display("FAIL br_slot_ds got %b want 1", F_Delayslot);
    end
    tick();
    idle_inputs();
    #1;
    n_tests += 2;
    if (F_PC !== 32'h3100) begin
      n_fail++; $display("FAIL br_target_pc got %h want %h", F_PC, 32'h3100);
    end
    if (F_Delayslot !== 1'b0) begin
      n_fail++; $display("FAIL br_target_ds got %b want 0", F_Delayslot);
    end
  endtask

  task automatic test_eret();
    D_eret = 1'b1; EPC = 32'h3040; D_is_bj = 1'b1;
    #1;
    n_tests += 3;
    if (F_PC !== 32'h3040 || i_inst_addr !== 32'h3040) begin
      n_fail++; $display("FAIL eret_same_pc got %h/%h want %h", F_PC, i_inst_addr, 32'h3040);
    end
    if (F_Delayslot !== 1'b0) begin
      n_fail++; $display("FAIL eret_ds got %b want 0", F_Delayslot);
    end
    if (F_Instr !== im_word(32'h3040)) begin
      n_fail++; $display("FAIL eret_instr got %h want %h", F_Instr, im_word(32'h3040));
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (F_PC !== 32'h3044) begin
      n_fail++; $display("FAIL eret_next got %h want %h", F_PC, 32'h3044);
    end
    // Stalled eret: EPC shown now, pc_q held.
    D_eret = 1'b1; EPC = 32'h3200; WrEn = 1'b0;
    #1;
    n_tests++;
    if (F_PC !== 32'h3200) begin
      n_fail++; $display("FAIL eret_stall_pc got %h want %h", F_PC, 32'h3200);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (F_PC !== 32'h3044) begin
      n_fail++; $display("FAIL eret_stall_hold got %h want %h", F_PC, 32'h3044);
    end
  endtask

  task automatic test_addr_error();
    logic [31:0] tgt [4];
    logic [4:0]  exp_exc [4];
    tgt[0] = 32'h3002; exp_exc[0] = 5'd4;
    tgt[1] = 32'h7000; exp_exc[1] = 5'd4;
    tgt[2] = 32'h2ffc; exp_exc[2] = 5'd4;
    tgt[3] = 32'h6ffc; exp_exc[3] = 5'd0;
    for (int i = 0; i < 4; i++) begin
      D_jump = 1'b1; D_jump_target = tgt[i];
      tick();
      idle_inputs();
      #1;
      n_tests += 3;
      if (F_PC !== tgt[i]) begin
        n_fail++; $display("FAIL adel_pc%0d got %h want %h", i, F_PC, tgt[i]);
      end
      if (F_EXCcode !== exp_exc[i]) begin
        n_fail++; $display("FAIL adel_exc%0d got %0d want %0d", i, F_EXCcode, exp_exc[i]);
      end
      if (F_Instr !== ((exp_exc[i] != 0) ? 32'h0 : im_word(tgt[i]))) begin
        n_fail++; $display("FAIL adel_instr%0d got %h", i, F_Instr);
      end
    end
    // Sequential step off the top of IM.
    tick();
    n_tests++;
    if (F_PC !== 32'h7000 || F_EXCcode !== 5'd4) begin
      n_fail++; $display("FAIL adel_step got %h/%0d want 7000/4", F_PC, F_EXCcode);
    end
    D_eret = 1'b1; EPC = 32'h3001;
    #1;
    n_tests++;
    if (F_EXCcode !== 5'd4 || F_Instr !== 32'h0) begin
      n_fail++; $display("FAIL adel_eret got %0d/%h want 4/0", F_EXCcode, F_Instr);
    end
    idle_inputs();
  endtask

  task automatic test_req();
    WrEn = 1'b0; D_is_bj = 1'b1; D_br_taken = 1'b1; D_br_target = 32'h3100; Req = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (F_PC !== 32'h4180) begin
      n_fail++; $display("FAIL req_stall got %h want %h", F_PC, 32'h4180);
    end
    Req = 1'b1; D_eret = 1'b1; EPC = 32'h3300;
    #1;
    n_tests++;
    if (F_PC !== 32'h3300) begin
      n_fail++; $display("FAIL req_eret_same got %h want %h", F_PC, 32'h3300);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (F_PC !== 32'h4180) begin
      n_fail++; $display("FAIL req_eret_next got %h want %h", F_PC, 32'h4180);
    end
    Req = 1'b1; reset = 1'b1;
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (F_PC !== 32'h3000) begin
      n_fail++; $display("FAIL req_reset got %h want %h", F_PC, 32'h3000);
    end
  endtask

  function automatic logic [31:0] rand_target();
    unique case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'hffff_fffc;
      2:       return 32'h6ffc;
      3:       return 32'h3000 + ($urandom_range(0, 32'h0fff) << 2) + $urandom_range(0, 3);
      default: return 32'h3000 + ($urandom_range(0, 32'h0fff) << 2);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] exp_pc;
    pc = 32'h3000;
    reset = 1'b1;
    tick();
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 49) == 0);
      Req           = ($urandom_range(0, 19) == 0);
      WrEn          = ($urandom_range(0, 4) != 0);
      D_eret        = ($urandom_range(0, 9) == 0);
      EPC           = rand_target();
      D_jump        = ($urandom_range(0, 5) == 0);
      D_jump_target = rand_target();
      D_br_taken    = ($urandom_range(0, 3) == 0);
      D_br_target   = rand_target();
      D_is_bj       = $urandom_range(0, 1) == 1;
      #2;
      exp_pc = D_eret ? EPC : pc;
      n_tests += 4;
      if (F_PC !== exp_pc || i_inst_addr !== exp_pc) begin
        n_fail++; $display("FAIL rnd_pc c%0d got %h want %h", c, F_PC, exp_pc);
      end
      if (F_EXCcode !== (addr_illegal(exp_pc) ? 5'd4 : 5'd0)) begin
        n_fail++; $display("FAIL rnd_exc c%0d pc %h got %0d", c, exp_pc, F_EXCcode);
      end
      if (F_Instr !== (addr_illegal(exp_pc) ? 32'h0 : im_word(exp_pc))) begin
        n_fail++; $display("FAIL rnd_instr c%0d pc %h got %h", c, exp_pc, F_Instr);
      end
      if (F_Delayslot !== (D_is_bj && !D_eret)) begin
        n_fail++; $display("FAIL rnd_ds c%0d got %b want %b", c, F_Delayslot, D_is_bj && !D_eret);
      end
      if (reset)           pc = 32'h3000;
      else if (Req)        pc = 32'h4180;
      else if (!WrEn)      pc = pc;
      else if (D_eret)     pc = EPC + 4;
      else if (D_jump)     pc = D_jump_target;
      else if (D_br_taken) pc = D_br_target;
      else                 pc = pc + 4;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_eret();
    test_addr_error();
    test_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
Fetch stage of the P7 five-stage MIPS pipeline. It holds the architectural fetch PC and computes the next PC from stall, branch/jump, eret and exception-entry inputs. It drives the instruction-memory address and packages PC, instruction, delay-slot flag and fetch exception code for the F/D pipeline register, which sits directly downstream.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
EXC_ENTRY, 32'h0000_4180, handler entry PC on Req
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6ffc, highest legal fetch address (inclusive)
EXC_ADEL, 5'd4, ExcCode for a fetch address error

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
WrEn  input  1  1 = advance PC; 0 = stall (hold PC)
Req  input  1  exception/interrupt request from CP0; redirect to EXC_ENTRY
D_eret  input  1  instruction in D is eret
EPC  input  32  current EPC from CP0 (already forwarded)
D_br_taken  input  1  D-stage branch condition true
D_br_target  input  32  branch target computed in D
D_jump  input  1  D holds j/jal/jr/jalr
D_jump_target  input  32  jump target computed in D
D_is_bj  input  1  D holds any branch or jump (taken or not)
i_inst_addr  output  32  instruction-memory read address
i_inst_rdata  input  32  instruction word, combinational read of i_inst_addr
F_PC  output  32  PC of the fetched instruction
F_Instr  output  32  fetched instruction, or 0 on fetch error
F_Delayslot  output  1  fetched instruction is a delay-slot instruction
F_EXCcode  output  5  0 = none; EXC_ADEL on bad fetch address

Behaviour:
- State: one 32-bit register pc_q. There is no other architectural state.
- Effective fetch PC, combinational: F_PC = D_eret ? EPC : pc_q. i_inst_addr = F_PC. eret has no delay slot, so the EPC target is fetched in the same cycle eret sits in D, with no bubble.
- Next-state priority, evaluated each rising edge:
  1. reset: pc_q <= RESET_PC.
  2. Req: pc_q <= EXC_ENTRY. This overrides stall (WrEn ignored).
  3. !WrEn: pc_q holds.
  4. D_eret: pc_q <= EPC + 4.
  5. D_jump: pc_q <= D_jump_target.
  6. D_br_taken: pc_q <= D_br_target.
  7. Otherwise: pc_q <= pc_q + 4.
- Adds are 32-bit and wrap modulo 2^32. No carry is kept.
- Fetch error: the address is bad if F_PC[1:0] != 0, or F_PC < IM_BASE, or F_PC > IM_LIMIT (unsigned compare).
  - On a bad address: F_EXCcode = EXC_ADEL and F_Instr = 32'h0 (i_inst_rdata is ignored).
  - Otherwise: F_EXCcode = 0 and F_Instr = i_inst_rdata.
  - F_PC still carries the faulting PC so CP0 can write EPC/BadVAddr from it.
- F_Delayslot = D_is_bj & ~D_eret. The flag is combinational and does not depend on whether the branch is taken.
- Reset values: pc_q = RESET_PC, so after reset F_PC = 32'h3000, F_EXCcode = 0 (address legal), and F_Instr = the IM word at 0x3000. F_Delayslot follows its inputs.
- Simultaneous events:
  - Req together with D_eret or a branch: Req wins, pc_q <= EXC_ENTRY.
  - reset together with Req: reset wins.
  - Stall together with D_eret: F_PC = EPC is still presented combinationally. pc_q holds, and the redirect repeats on the next unstalled cycle.
- Reset mid-operation discards any pending redirect. There are no multi-cycle operations to abort.
- Outputs are combinational from pc_q and the inputs. Latency from a redirect input to the new F_PC is one clock edge, except eret, which takes effect in the same cycle.

Decomposition:
- Shared package `mips_defs`: RESET_PC, EXC_ENTRY, IM_BASE, IM_LIMIT, the ExcCode constants (EXC_NONE = 0, EXC_ADEL = 4, ...), and the 32-bit word type.
- One natural sub-module, `f_npc_sel`: the purely combinational next-PC priority mux. f_fetch_stage keeps the register, address check and output packaging.

Test Plan:
- Reset release, WrEn=1, no redirects for 3 cycles → F_PC sequence 0x3000, 0x3004, 0x3008, 0x300c; F_EXCcode=0.
- At pc_q=0x3010, WrEn=0 for 2 cycles, then WrEn=1 → F_PC stays 0x3010 for 2 cycles, then 0x3014.
- D_is_bj=1, D_br_taken=1, D_br_target=0x3100 at pc_q=0x3020 → this cycle F_Delayslot=1 with F_PC=0x3020; next cycle F_PC=0x3100, F_Delayslot=0.
- D_eret=1, EPC=0x3040, WrEn=1 → same cycle F_PC=0x3040 and F_Delayslot=0; next cycle F_PC=0x3044.
- D_jump_target=0x3002 taken → next cycle F_PC=0x3002, F_EXCcode=4, F_Instr=0. Separately, a redirect to 0x7000 → F_EXCcode=4.
- Req=1 with WrEn=0 and D_br_taken=1 → next cycle F_PC=0x4180. Req=1 with reset=1 → F_PC=0x3000.
